// File: rtl/enemy_pkg.sv
// Shared types and defaults for the enemy spawn scheduler.
// State encoding, spawn table entry and level geometry.
package enemy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OFFER,
    LEVEL_LOAD
  } state_e;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } spawn_entry_t;

  localparam int N_SLOTS_DEF        = 4;
  localparam int RESPAWN_FRAMES_DEF = 120;
  localparam int MAX_ALIVE_DEF      = 3;
  localparam int CNT_W_DEF          = 7;

  localparam logic [9:0] FLOOR_Y = 10'd400;

endpackage

// File: rtl/enemy_spawn_table.sv
// Per-level spawn table: (level, slot) -> enable and start position.
// Purely combinational; unknown levels have every slot disabled.
module enemy_spawn_table
  import enemy_pkg::*;
(
  input  logic [2:0]   level_i,
  input  logic [1:0]   slot_i,
  output spawn_entry_t entry_o
);

  // Lookup of the start coordinates for the addressed slot
  always_comb begin
    entry_o = '0;
    unique case (level_i)
      3'd1: begin
        unique case (slot_i)
          2'd0:    entry_o = '{en: 1'b1, x: 10'd600, y: FLOOR_Y};
          2'd1:    entry_o = '{en: 1'b1, x: 10'd450, y: FLOOR_Y};
          default: entry_o = '0;
        endcase
      end
      3'd2: begin
        unique case (slot_i)
          2'd0:    entry_o = '{en: 1'b1, x: 10'd600, y: FLOOR_Y};
          2'd1:    entry_o = '{en: 1'b1, x: 10'd500, y: FLOOR_Y};
          2'd2:    entry_o = '{en: 1'b1, x: 10'd400, y: FLOOR_Y};
          default: entry_o = '{en: 1'b1, x: 10'd300, y: FLOOR_Y};
        endcase
      end
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Per-frame enemy slot scheduler: kills, respawn countdowns, capped
// spawning and a valid/ready spawn offer toward the enemy instances.
module enemy_spawn_scheduler
  import enemy_pkg::*;
#(
  parameter int N_SLOTS        = N_SLOTS_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter int MAX_ALIVE      = MAX_ALIVE_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [2:0]         level_num,
  input  logic [N_SLOTS-1:0] enemy_dead,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [1:0]         spawn_slot,
  output logic [9:0]         spawn_x,
  output logic [9:0]         spawn_y,
  output logic [N_SLOTS-1:0] slot_active,
  output logic               busy
);

  localparam int AW = $clog2(N_SLOTS + 1);
  localparam logic [1:0] LAST = 2'(N_SLOTS - 1);

  logic fclk_q1, fclk_q2, fclk_q3;
  logic frame_tick;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [N_SLOTS-1:0] active_q, active_d;
  logic [CNT_W-1:0]   cnt_q [N_SLOTS];
  logic [CNT_W-1:0]   cnt_d [N_SLOTS];
  logic [AW-1:0]      alive_q, alive_d;
  logic               pending_q, pending_d;
  logic [2:0]         level_q, level_d;
  logic               valid_q, valid_d;
  logic [1:0]         slot_q, slot_d;
  logic [9:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic               adv;
  logic               level_chg;
  spawn_entry_t       ent;

  enemy_spawn_table u_table (
    .level_i (level_q),
    .slot_i  (idx_q),
    .entry_o (ent)
  );

  // Bring frame_clk into the Clk domain; third flop holds the last value
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fclk_q1 <= 1'b0;
      fclk_q2 <= 1'b0;
      fclk_q3 <= 1'b0;
    end else begin
      fclk_q1 <= frame_clk;
      fclk_q2 <= fclk_q1;
      fclk_q3 <= fclk_q2;
    end
  end

  assign frame_tick = fclk_q2 & ~fclk_q3;
  assign level_chg  = (level_num != level_q);

  // Next-state: level change wins, otherwise the scan/offer machine
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    alive_d   = alive_q;
    pending_d = pending_q;
    level_d   = level_q;
    valid_d   = valid_q;
    slot_d    = slot_q;
    x_d       = x_q;
    y_d       = y_q;
    adv       = 1'b0;
    if (level_chg && state_q != LEVEL_LOAD) begin
      state_d = LEVEL_LOAD;
      valid_d = 1'b0;
    end else begin
      if (frame_tick && state_q != IDLE) pending_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
        SCAN: begin
          if (active_q[idx_q] && enemy_dead[idx_q]) begin
            active_d[idx_q] = 1'b0;
            alive_d         = alive_q - AW'(1);
            cnt_d[idx_q]    = CNT_W'(RESPAWN_FRAMES);
            adv             = 1'b1;
          end else if (!active_q[idx_q] && cnt_q[idx_q] != '0) begin
            cnt_d[idx_q] = cnt_q[idx_q] - CNT_W'(1);
            adv          = 1'b1;
          end else if (!active_q[idx_q] && ent.en &&
                       alive_q < AW'(MAX_ALIVE)) begin
            state_d = OFFER;
            valid_d = 1'b1;
            slot_d  = idx_q;
            x_d     = ent.x;
            y_d     = ent.y;
          end else begin
            adv = 1'b1;
          end
        end
        OFFER: begin
          if (spawn_ready) begin
            active_d[idx_q] = 1'b1;
            alive_d         = alive_q + AW'(1);
            valid_d         = 1'b0;
            adv             = 1'b1;
          end
        end
        LEVEL_LOAD: begin
          active_d = '0;
          for (int i = 0; i < N_SLOTS; i++) cnt_d[i] = '0;
          alive_d   = '0;
          pending_d = 1'b0;
          valid_d   = 1'b0;
          level_d   = level_num;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (adv) begin
        if (idx_q == LAST) begin
          idx_d = '0;
          if (pending_q || frame_tick) begin
            state_d   = SCAN;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = SCAN;
          idx_d   = idx_q + 2'd1;
        end
      end
    end
  end

  // Scheduler state registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      active_q  <= '0;
      for (int i = 0; i < N_SLOTS; i++) cnt_q[i] <= '0;
      alive_q   <= '0;
      pending_q <= 1'b0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      slot_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      alive_q   <= alive_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      slot_q    <= slot_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_slot  = slot_q;
  assign spawn_x     = x_q;
  assign spawn_y     = y_q;
  assign slot_active = active_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Randomized bench for enemy_spawn_scheduler against a frame-level
// model of the slot rules (kill, countdown, capped table spawn).
module tb_enemy_spawn_scheduler;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [2:0] level_num;
  logic [3:0] enemy_dead;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [1:0] spawn_slot;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [3:0] slot_active;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  int       m_level;
  bit [3:0] m_act;
  int       m_cnt [4];
  int       exp_q [$];

  enemy_spawn_scheduler dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .level_num   (level_num),
    .enemy_dead  (enemy_dead),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_slot  (spawn_slot),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .slot_active (slot_active),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int enc(input int s, input int x, input int y);
    return (s << 20) | (x << 10) | y;
  endfunction

  function automatic void tbl(input int lv, input int s, output bit en,
                              output int x, output int y);
    en = 0; x = 0; y = 0;
    if (lv == 1 && s < 2) begin
      en = 1; x = (s == 0) ? 600 : 450; y = 400;
    end else if (lv == 2) begin
      en = 1; x = 600 - 100 * s; y = 400;
    end
  endfunction

  task automatic model_clear(input int lv);
    m_level = lv;
    m_act = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_frame(input bit [3:0] dead);
    bit en;
    int x, y;
    exp_q.delete();
    for (int s = 0; s < 4; s++) begin
      tbl(m_level, s, en, x, y);
      if (m_act[s] && dead[s]) begin
        m_act[s] = 0;
        m_cnt[s] = 120;
      end else if (!m_act[s] && m_cnt[s] > 0) begin
        m_cnt[s]--;
      end else if (!m_act[s] && en && $countones(m_act) < 3) begin
        exp_q.push_back(enc(s, x, y));
        m_act[s] = 1;
      end
    end
  endtask

  task automatic set_level(input int lv);
    @(negedge Clk);
    level_num = 3'(lv);
    repeat (3) @(negedge Clk);
    if (lv != m_level) model_clear(lv);
    check("level_idle", busy, 0);
  endtask

  task automatic run_frame(input bit [3:0] dead, input bit rnd);
    int got_q [$];
    int cyc = 0;
    int first = -1;
    bit seen = 0;
    bit done = 0;
    bit r;
    bit pend = 0;
    int pv = 0;
    model_frame(dead);
    enemy_dead = dead;
    @(negedge Clk);
    frame_clk = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 5) frame_clk = 1'b0;
      if (spawn_valid && first < 0) first = cyc;
      if (busy) seen = 1;
      if (pend && spawn_valid)
        check("offer_hold", enc(spawn_slot, spawn_x, spawn_y), pv);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      spawn_ready = r;
      pend = spawn_valid && !r;
      pv = enc(spawn_slot, spawn_x, spawn_y);
      if (spawn_valid && r)
        got_q.push_back(enc(spawn_slot, spawn_x, spawn_y));
      if (seen && !busy && cyc >= 5) done = 1;
    end
    check("frame_timeout", done, 1);
    check("n_offers", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("offer", got_q[i], exp_q[i]);
    if (exp_q.size() > 0) check("latency", first, 4 + (exp_q[0] >> 20));
    check("slot_active", slot_active, m_act);
    enemy_dead = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ref_v, bad, b, k;
    int got_q [$];
    int e_q [$];
    bit [3:0] d;

    Reset = 1'b1;
    frame_clk = 1'b0;
    level_num = 3'd1;
    enemy_dead = '0;
    spawn_ready = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_valid", spawn_valid, 0);
    check("rst_slot", spawn_slot, 0);
    check("rst_x", spawn_x, 0);
    check("rst_y", spawn_y, 0);
    check("rst_active", slot_active, 0);
    check("rst_busy", busy, 0);
    Reset = 1'b0;
    model_clear(1);
    repeat (3) @(negedge Clk);

    // level 1 first frame, then slot 0 kill and 120-frame respawn wait
    run_frame(4'b0000, 0);
    run_frame(4'b0001, 0);
    for (int f = 0; f < 121; f++) run_frame(4'b0000, 0);

    // level 2: cap at three, then kill slot 1 and slot 3 fills in
    set_level(2);
    run_frame(4'b0000, 0);
    run_frame(4'b0010, 0);

    // offer held under backpressure, tick during hold queues a rescan
    set_level(1);
    set_level(2);
    model_frame(4'b0000);
    e_q = exp_q;
    model_frame(4'b0000);
    spawn_ready = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    k = 0;
    while (!spawn_valid && k < 20) begin
      @(negedge Clk);
      k++;
      if (k == 5) frame_clk = 1'b0;
    end
    frame_clk = 1'b0;
    check("hold_valid_up", spawn_valid, 1);
    ref_v = enc(spawn_slot, spawn_x, spawn_y);
    check("hold_first", ref_v, e_q[0]);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (i == 10) frame_clk = 1'b1;
      if (i == 16) frame_clk = 1'b0;
      if (!spawn_valid || enc(spawn_slot, spawn_x, spawn_y) != ref_v)
        bad++;
    end
    check("hold_stable", bad, 0);
    spawn_ready = 1'b1;
    got_q.delete();
    got_q.push_back(enc(spawn_slot, spawn_x, spawn_y));
    b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (spawn_valid) got_q.push_back(enc(spawn_slot, spawn_x, spawn_y));
      if (!busy) break;
      b++;
    end
    check("pending_rescan", b, 9);
    check("hold_n_offers", got_q.size(), e_q.size());
    for (int i = 0; i < got_q.size() && i < e_q.size(); i++)
      check("hold_offer", got_q[i], e_q[i]);
    check("hold_active", slot_active, m_act);

    // level change aborts an offer in progress
    set_level(1);
    spawn_ready = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    k = 0;
    while (!(spawn_valid && k >= 5) && k < 20) begin
      @(negedge Clk);
      k++;
      if (k == 5) frame_clk = 1'b0;
    end
    frame_clk = 1'b0;
    check("lc_valid_up", spawn_valid, 1);
    level_num = 3'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      if (!spawn_valid) break;
    end
    check("lc_drop", spawn_valid, 0);
    repeat (2) @(negedge Clk);
    check("lc_active", slot_active, 0);
    check("lc_busy", busy, 0);
    model_clear(2);
    run_frame(4'b0000, 0);

    // randomized frames: kills, ready backpressure, level switches
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) set_level($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) d[i] = ($urandom_range(0, 3) == 0);
      run_frame(d, 1);
    end

    // async reset in the middle of an offer
    set_level(3);
    set_level(1);
    spawn_ready = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    k = 0;
    while (!(spawn_valid && k >= 5) && k < 20) begin
      @(negedge Clk);
      k++;
      if (k == 5) frame_clk = 1'b0;
    end
    frame_clk = 1'b0;
    check("rst_offer_up", spawn_valid, 1);
    #2 Reset = 1'b1;
    #1;
    check("arst_valid", spawn_valid, 0);
    check("arst_slot", spawn_slot, 0);
    check("arst_x", spawn_x, 0);
    check("arst_y", spawn_y, 0);
    check("arst_active", slot_active, 0);
    check("arst_busy", busy, 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_clear(1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (spawn_valid) bad++;
    end
    check("arst_quiet", bad, 0);
    run_frame(4'b0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
